// File: rtl/cmp_seq_ctrl.sv
// Initiator-side sequencer for the ALU compare unit: issues one compare per request and
// returns a checked result over a valid/ready response, with timeout and error counting.
module cmp_seq_ctrl #(
    parameter int IN_DATA_WD = 16,
    parameter int OUT_WD     = IN_DATA_WD,
    parameter int TIMEOUT    = 4,
    parameter int ERR_CNT_WD = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [IN_DATA_WD-1:0] req_a_i,
    input  logic [IN_DATA_WD-1:0] req_b_i,
    input  logic [1:0]            req_fun_i,
    output logic [IN_DATA_WD-1:0] cmp_a_o,
    output logic [IN_DATA_WD-1:0] cmp_b_o,
    output logic [1:0]            cmp_fun_o,
    output logic                  cmp_en_o,
    input  logic [OUT_WD-1:0]     cmp_out_i,
    input  logic                  cmp_flag_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_true_o,
    output logic [1:0]            rsp_code_o,
    output logic                  rsp_err_o,
    output logic [ERR_CNT_WD-1:0] err_cnt_o
);

    // state  | meaning
    // IDLE   | ready for a request, operands held from the last one
    // ISSUE  | compare enable high for exactly one cycle
    // WAIT   | watching for the unit flag while the timer counts down
    // RESP   | response presented until the consumer takes it
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int TMR_WD = $clog2(TIMEOUT + 1);
    localparam logic [TMR_WD-1:0] TMR_LOAD = TMR_WD'(TIMEOUT);
    localparam logic [TMR_WD-1:0] TMR_ONE  = TMR_WD'(1);

    state_e                  state_q, state_d;
    logic [TMR_WD-1:0]       timer_q, timer_d;
    logic [IN_DATA_WD-1:0]   cmp_a_q, cmp_a_d;
    logic [IN_DATA_WD-1:0]   cmp_b_q, cmp_b_d;
    logic [1:0]              cmp_fun_q, cmp_fun_d;
    logic                    cmp_en_q, cmp_en_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_true_q, rsp_true_d;
    logic [1:0]              rsp_code_q, rsp_code_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [ERR_CNT_WD-1:0]   err_cnt_q, err_cnt_d;

    logic [OUT_WD-1:0]       fun_ext;
    logic                    code_match;
    logic                    code_ok;
    logic                    enter_resp;

    // A code is legal only if it is zero or exactly the issued function; the full-width
    // compare also rejects anything set above bit 1.
    assign fun_ext    = OUT_WD'(cmp_fun_q);
    assign code_match = (cmp_out_i == fun_ext);
    assign code_ok    = (cmp_out_i == '0) || code_match;

    assign req_ready_o = (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cmp_a_d     = cmp_a_q;
        cmp_b_d     = cmp_b_q;
        cmp_fun_d   = cmp_fun_q;
        cmp_en_d    = cmp_en_q;
        rsp_valid_d = rsp_valid_q;
        rsp_true_d  = rsp_true_q;
        rsp_code_d  = rsp_code_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    cmp_a_d   = req_a_i;
                    cmp_b_d   = req_b_i;
                    cmp_fun_d = req_fun_i;
                    cmp_en_d  = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmp_en_d = 1'b0;
                timer_d  = TMR_LOAD;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // Flag is checked before expiry so a flag on the last timer cycle still wins.
                if (cmp_flag_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = cmp_out_i[1:0];
                    rsp_true_d  = code_match && (cmp_fun_q != 2'b00);
                    rsp_err_d   = !code_ok;
                    enter_resp  = 1'b1;
                    state_d     = ST_RESP;
                end else if (timer_q == TMR_ONE) begin
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = 2'b00;
                    rsp_true_d  = 1'b0;
                    rsp_err_d   = 1'b1;
                    enter_resp  = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (enter_resp && rsp_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WD'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            cmp_fun_q   <= 2'b00;
            cmp_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_true_q  <= 1'b0;
            rsp_code_q  <= 2'b00;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            cmp_fun_q   <= cmp_fun_d;
            cmp_en_q    <= cmp_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_true_q  <= rsp_true_d;
            rsp_code_q  <= rsp_code_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmp_a_o     = cmp_a_q;
    assign cmp_b_o     = cmp_b_q;
    assign cmp_fun_o   = cmp_fun_q;
    assign cmp_en_o    = cmp_en_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_true_o  = rsp_true_q;
    assign rsp_code_o  = rsp_code_q;
    assign rsp_err_o   = rsp_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: plays requester, compare unit and response consumer, checking
// each transaction against expectations derived from the compare rules and flag timing.
module tb_cmp_seq_ctrl;

    localparam int DW      = 16;
    localparam int OW      = 16;
    localparam int TMO     = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic [1:0]    req_fun = 2'b00;
    logic [DW-1:0] cmp_a;
    logic [DW-1:0] cmp_b;
    logic [1:0]    cmp_fun;
    logic          cmp_en;
    logic [OW-1:0] cmp_out = '0;
    logic          cmp_flag = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_true;
    logic [1:0]    rsp_code;
    logic          rsp_err;
    logic [CW-1:0] err_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cmp_seq_ctrl #(
        .IN_DATA_WD(DW),
        .OUT_WD    (OW),
        .TIMEOUT   (TMO),
        .ERR_CNT_WD(CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_a_i    (req_a),
        .req_b_i    (req_b),
        .req_fun_i  (req_fun),
        .cmp_a_o    (cmp_a),
        .cmp_b_o    (cmp_b),
        .cmp_fun_o  (cmp_fun),
        .cmp_en_o   (cmp_en),
        .cmp_out_i  (cmp_out),
        .cmp_flag_i (cmp_flag),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_true_o (rsp_true),
        .rsp_code_o (rsp_code),
        .rsp_err_o  (rsp_err),
        .err_cnt_o  (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; asserts reset mid-cycle and checks outputs before any clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_en", 32'(cmp_en), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_cnt", 32'(err_cnt), 0);
        chk("rst_cmp_a", 32'(cmp_a), 0);
        chk("rst_fun", 32'(cmp_fun), 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_true", 32'(rsp_true), 0);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_cnt_rel", 32'(err_cnt), 0);
    endtask

    // One request/response. k = WAIT cycle index at which the unit raises its flag
    // (k >= TMO means the flag never comes). hold = cycles of response backpressure.
    task automatic txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] fun,
                       input logic [OW-1:0] out, input int k, input int hold);
        bit         tmo;
        int         last;
        int         o;
        int         f;
        int         e_true;
        int         e_err;
        int         e_code;
        tmo = (k >= TMO);
        last = tmo ? TMO - 1 : k;
        o = int'(out);
        f = int'(fun);
        if (tmo) begin
            e_true = 0;
            e_code = 0;
            e_err  = 1;
        end else begin
            e_code = o % 4;
            e_true = ((o == f) && (f != 0)) ? 1 : 0;
            e_err  = ((o != 0) && (o != f)) ? 1 : 0;
        end

        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_fun = fun;
        cmp_flag = 1'($urandom_range(0, 1));
        cmp_out = 16'($urandom);
        chk("ready_idle", 32'(req_ready), 1);
        cyc();
        req_valid = 1'b0;
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        req_fun = 2'($urandom);
        cmp_flag = 1'($urandom_range(0, 1));
        chk("en_issue", 32'(cmp_en), 1);
        chk("cmp_a", 32'(cmp_a), 32'(a));
        chk("cmp_b", 32'(cmp_b), 32'(b));
        chk("cmp_fun", 32'(cmp_fun), 32'(fun));
        chk("ready_issue", 32'(req_ready), 0);
        chk("valid_issue", 32'(rsp_valid), 0);
        cyc();
        chk("en_drop", 32'(cmp_en), 0);
        for (int i = 0; i <= last; i++) begin
            chk("valid_wait", 32'(rsp_valid), 0);
            chk("ready_wait", 32'(req_ready), 0);
            cmp_flag = (i == k);
            cmp_out = (i == k) ? out : 16'($urandom);
            cyc();
        end
        cmp_flag = 1'($urandom_range(0, 1));
        cmp_out = 16'($urandom);
        if (e_err == 1 && exp_cnt < CNT_MAX) exp_cnt++;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_true", 32'(rsp_true), e_true);
        chk("rsp_code", 32'(rsp_code), e_code);
        chk("rsp_err", 32'(rsp_err), e_err);
        chk("err_cnt", 32'(err_cnt), exp_cnt);
        chk("ready_resp", 32'(req_ready), 0);
        chk("en_resp", 32'(cmp_en), 0);
        rsp_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_a = 16'($urandom);
            req_fun = 2'($urandom);
            cmp_flag = 1'($urandom_range(0, 1));
            cmp_out = 16'($urandom);
            cyc();
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_true", 32'(rsp_true), e_true);
            chk("bp_code", 32'(rsp_code), e_code);
            chk("bp_err", 32'(rsp_err), e_err);
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_cnt", 32'(err_cnt), exp_cnt);
            chk("bp_cmp_a", 32'(cmp_a), 32'(a));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        cmp_flag = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 0);
        chk("ready_back", 32'(req_ready), 1);
        chk("keep_code", 32'(rsp_code), e_code);
        chk("keep_err", 32'(rsp_err), e_err);
        chk("keep_true", 32'(rsp_true), e_true);
        chk("keep_cmp_a", 32'(cmp_a), 32'(a));
        chk("keep_cnt", 32'(err_cnt), exp_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  f;
        logic [15:0] o;
        int          sel;

        @(negedge clk);
        async_reset();

        // equality true, nominal latency
        txn(16'h1234, 16'h1234, 2'b01, 16'h0001, 0, 0);
        // gt false then lt true back-to-back
        txn(16'd5, 16'd9, 2'b10, 16'h0000, 0, 0);
        txn(16'd5, 16'd9, 2'b11, 16'h0003, 0, 0);
        // backpressure for 5 cycles
        txn(16'h00aa, 16'h0055, 2'b10, 16'h0002, 1, 5);
        // nop is issued and is clean
        txn(16'h0001, 16'h0002, 2'b00, 16'h0000, 0, 0);
        // timeout: first error
        txn(16'h0007, 16'h0007, 2'b01, 16'h0001, TMO + 1, 0);
        chk("cnt_after_tmo", 32'(err_cnt), 1);
        // flag on the expiry cycle wins
        txn(16'h0003, 16'h0003, 2'b01, 16'h0001, TMO - 1, 0);
        // illegal code
        txn(16'h0009, 16'h0002, 2'b10, 16'h0001, 0, 0);
        // code with upper bits set
        txn(16'h0009, 16'h0002, 2'b10, 16'h0102, 2, 0);

        for (int n = 0; n < 60; n++) begin
            f = 2'($urandom);
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: o = 16'h0000;
                1: o = {14'b0, f};
                2: o = 16'($urandom_range(0, 3));
                default: o = 16'($urandom);
            endcase
            txn(16'($urandom), 16'($urandom), f, o, int'($urandom_range(0, TMO + 1)),
                int'($urandom_range(0, 3)));
        end

        // drive the counter to saturation
        for (int n = 0; n < 300; n++) begin
            f = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                txn(16'($urandom), 16'($urandom), f, 16'($urandom), TMO, 0);
            end else begin
                o = 16'($urandom) | 16'h0100;
                txn(16'($urandom), 16'($urandom), f, o, int'($urandom_range(0, TMO - 1)), 0);
            end
        end
        chk("cnt_saturated", 32'(err_cnt), CNT_MAX);

        // reset in the middle of WAIT: no response may appear afterwards
        req_valid = 1'b1;
        req_a = 16'h4321;
        req_b = 16'h4321;
        req_fun = 2'b01;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        chk("mid_wait_busy", 32'(req_ready), 0);
        async_reset();
        cmp_flag = 1'b1;
        cmp_out = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_valid", 32'(rsp_valid), 0);
            chk("post_rst_en", 32'(cmp_en), 0);
            chk("post_rst_ready", 32'(req_ready), 1);
        end
        cmp_flag = 1'b0;
        txn(16'h0010, 16'h0020, 2'b11, 16'h0003, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
- Initiator-side controller for the ALU compare unit.
- Accepts compare requests over a valid/ready handshake and drives the compare unit's operand, function and enable inputs for exactly one cycle.
- Waits for the unit's flag, then decodes and checks the returned code.
- Presents the result over a valid/ready response handshake, with a timeout and a saturating error counter.

Parameters:
- IN_DATA_WD, 16: operand width; matches the compare unit.
- OUT_WD, IN_DATA_WD: width of the compare unit's result bus.
- TIMEOUT, 4: cycles to wait for the flag after issue, minimum 1.
- ERR_CNT_WD, 8: width of the error counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request ready.
- REQ_A  in  IN_DATA_WD  operand A.
- REQ_B  in  IN_DATA_WD  operand B.
- REQ_FUN  in  2  function: 00 nop, 01 eq, 10 gt, 11 lt.
- CMP_A  out  IN_DATA_WD  operand A to the compare unit.
- CMP_B  out  IN_DATA_WD  operand B to the compare unit.
- CMP_FUN  out  2  function to the compare unit.
- CMP_EN  out  1  compare enable.
- CMP_OUT  in  OUT_WD  compare result code.
- CMP_FLAG  in  1  compare result valid.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response ready.
- RSP_TRUE  out  1  compare condition true.
- RSP_CODE  out  2  captured CMP_OUT[1:0].
- RSP_ERR  out  1  timeout or illegal code.
- ERR_CNT  out  ERR_CNT_WD  count of responses with RSP_ERR=1, saturating.

Behaviour:
- Reset (RST=1, asynchronous): state IDLE; all registered outputs 0, including CMP_EN, RSP_VALID and ERR_CNT; timer 0; REQ_READY=1 once in IDLE.
- Reset mid-operation aborts the operation: CMP_EN and RSP_VALID drop immediately, and any pending response is lost.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- REQ_READY is 1 only in IDLE, decoded combinationally from state. No request is accepted while a response is pending.
- IDLE: on REQ_VALID&&REQ_READY at a rising edge:
  - register REQ_A, REQ_B, REQ_FUN into CMP_A, CMP_B, CMP_FUN;
  - set CMP_EN=1;
  - go to ISSUE.
- CMP_A, CMP_B and CMP_FUN hold their values until the next accepted request.
- ISSUE: lasts exactly one cycle with CMP_EN=1. On exit: CMP_EN=0, timer loaded with TIMEOUT, go to WAIT.
- WAIT, when CMP_FLAG=1, capture the result and go to RESP with RSP_VALID=1:
  - RSP_CODE = CMP_OUT[1:0].
  - RSP_TRUE = (CMP_OUT == CMP_FUN) && (CMP_FUN != 0).
  - RSP_ERR = 1 if CMP_OUT is neither 0 nor CMP_FUN, or if any CMP_OUT bit above bit 1 is set.
- WAIT, when CMP_FLAG=0: decrement the timer. When the timer is 1 and the flag is still 0, go to RESP with RSP_ERR=1, RSP_TRUE=0, RSP_CODE=0.
- Nominal latency:
  - request accepted at edge n;
  - CMP_EN high during cycle n..n+1;
  - CMP_FLAG seen in WAIT at edge n+2;
  - RSP_VALID high after edge n+2.
- RESP: RSP_VALID and all RSP_* fields held stable until RSP_READY=1 at a rising edge. Then RSP_VALID=0 and the FSM returns to IDLE; the other RSP_* fields keep their last values.
- ERR_CNT increments by 1 on the edge that enters RESP with RSP_ERR=1. It saturates at all-ones and is cleared only by reset.
- CMP_FLAG in IDLE, ISSUE or RESP is ignored, including stale flags.
- A flag arriving in the same cycle the timer expires counts as success: the flag wins.
- FUN=00 (nop) is still issued: expected CMP_OUT=0, giving RSP_TRUE=0 and RSP_ERR=0.

Test Plan:
- Reset then idle: assert RST asynchronously mid-cycle -> all outputs 0 immediately; after release REQ_READY=1, ERR_CNT=0.
- Equality true: A=0x1234, B=0x1234, FUN=01, unit returns CMP_OUT=1, RSP_READY=1 -> CMP_EN high exactly 1 cycle; RSP_VALID 2 edges after accept with RSP_TRUE=1, RSP_CODE=01, RSP_ERR=0.
- Gt false, then lt true back-to-back:
  - First: A=5, B=9, FUN=10, unit returns 0 -> RSP_TRUE=0, RSP_ERR=0.
  - Second: FUN=11, unit returns 3 -> RSP_TRUE=1, RSP_CODE=11.
  - REQ_READY=0 throughout RESP.
- Backpressure: hold RSP_READY=0 for 5 cycles -> RSP_* stable, REQ_VALID ignored; RSP_READY=1 -> RSP_VALID=0 and back to IDLE next cycle.
- Timeout: FUN=01 with CMP_FLAG held 0, TIMEOUT=4 -> RSP_VALID with RSP_ERR=1, RSP_CODE=0, ERR_CNT=1.
- Illegal code and saturation:
  - FUN=10 with unit returning 1 -> RSP_ERR=1.
  - Repeat 300 error responses with ERR_CNT_WD=8 -> ERR_CNT stops at 255.
  - Reset mid-WAIT -> FSM in IDLE, no response issued.
